// File: rtl/regfile.sv
// regfile: 32 x WIDTH integer register file with two combinational read
// ports, one clocked write port and the operand-B mux for the ALU.
// x0 reads as zero and ignores writes. Reset clears every register at once,
// without waiting for a clock edge.

// One storage register; one instance per architectural register x1..x(N-1).
module regfile_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset clears the register immediately; otherwise load d when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

module regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [4:0]       a1,
  input  logic [4:0]       a2,
  input  logic [4:0]       a3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [WIDTH-1:0] imm,
  input  logic             alusrc,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] srcb
);

  logic [NREGS-1:0][WIDTH-1:0] regs;

  // x0 has no storage at all. Each other register gets its own write strobe
  // decoded from a3, so an address of 0 or one above NREGS-1 enables nothing.
  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_reg
      if (i == 0) begin : g_zero
        assign regs[i] = '0;
      end else begin : g_cell
        regfile_cell #(.WIDTH(WIDTH)) u_cell (
          .clk   (clk),
          .reset (reset),
          .en    (we3 && (a3 == 5'(i))),
          .d     (wd3),
          .q     (regs[i])
        );
      end
    end
  endgenerate

  // Read port 1: combinational, and no bypass from the write port, so a
  // same-cycle write only becomes visible after the edge.
  always_comb begin
    rd1 = '0;
    if ((a1 != 5'd0) && (int'({27'd0, a1}) < NREGS)) rd1 = regs[a1];
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    rd2 = '0;
    if ((a2 != 5'd0) && (int'({27'd0, a2}) < NREGS)) rd2 = regs[a2];
  end

  // Operand-B select. imm arrives already extended, so it passes through
  // with no width change or sign handling.
  always_comb begin
    srcb = alusrc ? imm : rd2;
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed vectors for regfile. Stimulus queues hand-computed
// expectations and fires a sample event; a separate monitor drains the queue
// and compares each entry against the live DUT outputs.
module tb_regfile;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             we3;
  logic [4:0]       a1, a2, a3;
  logic [WIDTH-1:0] wd3, imm;
  logic             alusrc;
  logic [WIDTH-1:0] rd1, rd2, srcb;

  regfile #(.WIDTH(WIDTH), .NREGS(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .we3    (we3),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .wd3    (wd3),
    .imm    (imm),
    .alusrc (alusrc),
    .rd1    (rd1),
    .rd2    (rd2),
    .srcb   (srcb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               sel;   // 0: rd1, 1: rd2, 2: srcb
    logic [WIDTH-1:0] exp;
    string            name;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  // Monitor: whenever stimulus says outputs are settled, compare every
  // queued expectation against the current DUT outputs.
  initial begin
    exp_t             e;
    logic [WIDTH-1:0] act;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          0:       act = rd1;
          1:       act = rd2;
          default: act = srcb;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input int sel, input logic [WIDTH-1:0] v, input string nm);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then hand the queue to the monitor.
  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  // Perform one write on the next rising edge, leaving we3 low afterwards.
  task automatic write_reg(input logic [4:0] addr, input logic [WIDTH-1:0] data);
    we3 = 1'b1; a3 = addr; wd3 = data;
    @(posedge clk); #1;
    we3 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0;
    wd3 = '0; imm = '0; alusrc = 1'b0;
    #2;

    // Reset: every address reads 0 on both ports.
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i);
      expect_out(0, 32'h0, $sformatf("reset_rd1_a%0d", i));
      expect_out(1, 32'h0, $sformatf("reset_rd2_a%0d", 31 - i));
      sample();
    end
    // During reset srcb still forwards imm.
    alusrc = 1'b1; imm = 32'h0000_0055;
    expect_out(2, 32'h0000_0055, "reset_srcb_imm");
    sample();
    alusrc = 1'b0;
    expect_out(2, 32'h0, "reset_srcb_rd2");
    sample();

    // Reset overrides a write on the same edge.
    write_reg(5'd4, 32'hCAFE_F00D);
    a1 = 5'd4;
    expect_out(0, 32'h0, "reset_blocks_write");
    sample();

    @(negedge clk);
    reset = 1'b0;

    // Basic write/read on both ports to the same register.
    write_reg(5'd5, 32'hDEAD_BEEF);
    a1 = 5'd5; a2 = 5'd5;
    expect_out(0, 32'hDEAD_BEEF, "basic_rd1");
    expect_out(1, 32'hDEAD_BEEF, "basic_rd2");
    sample();
    // we3 = 0 leaves contents alone.
    wd3 = 32'h1234_5678; a3 = 5'd5;
    @(posedge clk); #1;
    expect_out(0, 32'hDEAD_BEEF, "no_we_rd1");
    expect_out(1, 32'hDEAD_BEEF, "no_we_rd2");
    sample();

    // x0 protection.
    write_reg(5'd0, 32'hFFFF_FFFF);
    a1 = 5'd0; a2 = 5'd0;
    expect_out(0, 32'h0, "x0_rd1");
    expect_out(1, 32'h0, "x0_rd2");
    sample();

    // Read-during-write: old value before the edge, new value after.
    write_reg(5'd7, 32'h0000_0011);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h0000_0022; a1 = 5'd7;
    expect_out(0, 32'h0000_0011, "rdw_before");
    sample();
    @(posedge clk); #1;
    we3 = 1'b0;
    expect_out(0, 32'h0000_0022, "rdw_after");
    sample();

    // Operand mux.
    write_reg(5'd3, 32'hA5A5_A5A5);
    a2 = 5'd3; imm = 32'h0000_0010; alusrc = 1'b0;
    expect_out(2, 32'hA5A5_A5A5, "mux_rd2");
    expect_out(1, 32'hA5A5_A5A5, "mux_rd2_port_sel0");
    sample();
    alusrc = 1'b1;
    expect_out(2, 32'h0000_0010, "mux_imm");
    expect_out(1, 32'hA5A5_A5A5, "mux_rd2_port_sel1");
    sample();
    alusrc = 1'b0;

    // Earlier registers survive later writes.
    a1 = 5'd5; a2 = 5'd7;
    expect_out(0, 32'hDEAD_BEEF, "retain_x5");
    expect_out(1, 32'h0000_0022, "retain_x7");
    sample();

    // Async reset mid-run, between clock edges.
    write_reg(5'd1,  32'h0000_0001);
    write_reg(5'd31, 32'h8000_0000);
    a1 = 5'd1; a2 = 5'd31;
    expect_out(0, 32'h0000_0001, "pre_rst_x1");
    expect_out(1, 32'h8000_0000, "pre_rst_x31");
    sample();
    reset = 1'b1;
    expect_out(0, 32'h0, "async_rst_x1");
    expect_out(1, 32'h0, "async_rst_x31");
    expect_out(2, 32'h0, "async_rst_srcb");
    sample();
    @(negedge clk);
    reset = 1'b0;

    // First write after reset works normally; x5 stays cleared.
    write_reg(5'd9, 32'h0BAD_CAFE);
    a1 = 5'd9; a2 = 5'd5;
    expect_out(0, 32'h0BAD_CAFE, "post_rst_write");
    expect_out(1, 32'h0, "post_rst_x5");
    sample();

    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
